// File: rtl/gaussian_blur.sv
// 3x3 Gaussian blur (1 2 1 / 2 4 2 / 1 2 1, /16) over a raw frame in SRAM, raster order,
// one pixel every 11 cycles: 9 tap reads, a capture cycle, then the Gaussian SRAM write.
module gaussian_blur #(
  parameter int X_MAX = 5,
  parameter int Y_MAX = 5
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     new_trans,
  input  logic [$clog2(X_MAX)-1:0] max_x,
  input  logic [$clog2(X_MAX)-1:0] max_y,
  input  logic [7:0]               SRAM_in_raw,
  output logic                     read_SRAM_raw,
  output logic [$clog2(X_MAX):0]   x_addr_raw,
  output logic [$clog2(X_MAX):0]   y_addr_raw,
  output logic                     write_SRAM_gaus,
  output logic [$clog2(X_MAX):0]   x_addr_gaus,
  output logic [$clog2(X_MAX):0]   y_addr_gaus,
  output logic [7:0]               SRAM_gaus_wdata,
  output logic                     gaus_sample_flag,
  output logic                     gaus_done
);

  localparam int CW = $clog2(X_MAX);
  localparam int AW = CW + 1;
  localparam logic [CW-1:0] X_LIM = CW'(X_MAX - 1);
  localparam logic [CW-1:0] Y_LIM = CW'(Y_MAX - 1);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     tap_q, tap_d;
  logic [CW-1:0]  cx_q, cx_d, cy_q, cy_d;
  logic [CW-1:0]  mx_q, mx_d, my_q, my_d;
  logic [11:0]    acc_q, acc_d;

  logic           rd_q, rd_d;
  logic [AW-1:0]  xr_q, xr_d, yr_q, yr_d;
  logic           wr_q, wr_d;
  logic [AW-1:0]  xg_q, xg_d, yg_q, yg_d;
  logic [7:0]     wd_q, wd_d;
  logic           done_q, done_d;
  logic [7:0]     blur_val;

  // Offset index 0/1/2 means -1/0/+1; taps run row-major, dx innermost.
  function automatic logic [1:0] tap_dx(input logic [3:0] t);
    case (t)
      4'd0, 4'd3, 4'd6: tap_dx = 2'd0;
      4'd1, 4'd4, 4'd7: tap_dx = 2'd1;
      default:          tap_dx = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] tap_dy(input logic [3:0] t);
    case (t)
      4'd0, 4'd1, 4'd2: tap_dy = 2'd0;
      4'd3, 4'd4, 4'd5: tap_dy = 2'd1;
      default:          tap_dy = 2'd2;
    endcase
  endfunction

  // Weight as a shift: centre row/column each contribute a factor of 2.
  function automatic logic [1:0] tap_sh(input logic [3:0] t);
    tap_sh = {1'b0, tap_dx(t) == 2'd1} + {1'b0, tap_dy(t) == 2'd1};
  endfunction

  function automatic logic [AW-1:0] clamp(input logic [CW-1:0] c, input logic [1:0] d,
                                          input logic [CW-1:0] m);
    logic [CW-1:0] r;
    r = c;
    if (d == 2'd0 && c != '0) r = c - CW'(1);
    else if (d == 2'd2 && c < m) r = c + CW'(1);
    clamp = {1'b0, r};
  endfunction

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    mx_d     = mx_q;
    my_d     = my_q;
    acc_d    = acc_q;
    blur_val = 8'((acc_q + 12'(SRAM_in_raw) + 12'd8) >> 4);
    case (state_q)
      IDLE, DONE: begin
        if (new_trans) begin
          state_d = READ;
          tap_d   = '0;
          cx_d    = '0;
          cy_d    = '0;
          mx_d    = (max_x > X_LIM) ? X_LIM : max_x;
          my_d    = (max_y > Y_LIM) ? Y_LIM : max_y;
          acc_d   = '0;
        end
      end
      READ: begin
        // Data returning now belongs to the previous cycle's tap.
        if (tap_q != '0) acc_d = acc_q + (12'(SRAM_in_raw) << tap_sh(tap_q - 4'd1));
        if (tap_q == 4'd8) state_d = CAPT;
        else tap_d = tap_q + 4'd1;
      end
      CAPT: begin
        acc_d   = '0;
        state_d = WRITE;
      end
      WRITE: begin
        tap_d = '0;
        if (cx_q == mx_q && cy_q == my_q) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          if (cx_q == mx_q) begin
            cx_d = '0;
            cy_d = cy_q + CW'(1);
          end else begin
            cx_d = cx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state they belong to.
  always_comb begin
    rd_d   = (state_d == READ);
    xr_d   = rd_d ? clamp(cx_d, tap_dx(tap_d), mx_d) : '0;
    yr_d   = rd_d ? clamp(cy_d, tap_dy(tap_d), my_d) : '0;
    wr_d   = (state_d == WRITE);
    xg_d   = wr_d ? {1'b0, cx_d} : '0;
    yg_d   = wr_d ? {1'b0, cy_d} : '0;
    wd_d   = wr_d ? blur_val : '0;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      acc_q   <= '0;
      rd_q    <= 1'b0;
      xr_q    <= '0;
      yr_q    <= '0;
      wr_q    <= 1'b0;
      xg_q    <= '0;
      yg_q    <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      acc_q   <= acc_d;
      rd_q    <= rd_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      wr_q    <= wr_d;
      xg_q    <= xg_d;
      yg_q    <= yg_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
    end
  end

  assign read_SRAM_raw    = rd_q;
  assign x_addr_raw       = xr_q;
  assign y_addr_raw       = yr_q;
  assign write_SRAM_gaus  = wr_q;
  assign gaus_sample_flag = wr_q;
  assign x_addr_gaus      = xg_q;
  assign y_addr_gaus      = yg_q;
  assign SRAM_gaus_wdata  = wd_q;
  assign gaus_done        = done_q;

endmodule

// File: tb/tb_gaussian_blur.sv
// Bench for gaussian_blur: raw SRAM model, frame-level blur model, per-cycle output checks.
module tb_gaussian_blur;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       new_trans = 1'b0;
  logic [2:0] max_x = '0, max_y = '0;
  logic [7:0] SRAM_in_raw = '0;
  logic       read_SRAM_raw, write_SRAM_gaus, gaus_sample_flag, gaus_done;
  logic [3:0] x_addr_raw, y_addr_raw, x_addr_gaus, y_addr_gaus;
  logic [7:0] SRAM_gaus_wdata;

  gaussian_blur #(.X_MAX(5), .Y_MAX(5)) dut (
    .clk(clk), .n_rst(n_rst), .new_trans(new_trans), .max_x(max_x), .max_y(max_y),
    .SRAM_in_raw(SRAM_in_raw), .read_SRAM_raw(read_SRAM_raw), .x_addr_raw(x_addr_raw),
    .y_addr_raw(y_addr_raw), .write_SRAM_gaus(write_SRAM_gaus), .x_addr_gaus(x_addr_gaus),
    .y_addr_gaus(y_addr_gaus), .SRAM_gaus_wdata(SRAM_gaus_wdata),
    .gaus_sample_flag(gaus_sample_flag), .gaus_done(gaus_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] mem  [0:4][0:4];
  logic [7:0] gimg [0:4][0:4];

  // Model state: 0 idle, 1 running, 2 done; mcyc = cycle number within frame (1 = first read).
  int mstate = 0, mcyc = 0, mmx = 0, mmy = 0, mn = 0;
  int wcount = 0, first_w = 0, last_w = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampm(input int v, input int m);
    return (v < 0) ? 0 : ((v > m) ? m : v);
  endfunction

  function automatic int blur(input int x, input int y);
    int s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        s += (2 - (dx < 0 ? -dx : dx)) * (2 - (dy < 0 ? -dy : dy)) *
             int'(mem[clampm(y + dy, mmy)][clampm(x + dx, mmx)]);
    return (s + 8) / 16;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mstate = 0;
      mcyc = 0;
    end else if (mstate == 1) begin
      if (mcyc == 11 * mn) mstate = 2;
      else mcyc++;
    end else if (new_trans) begin
      mstate = 1; mcyc = 1;
      mmx = int'(max_x); mmy = int'(max_y); mn = (mmx + 1) * (mmy + 1);
      wcount = 0; first_w = 0; last_w = 0;
    end
  end

  // Raw SRAM: data valid the cycle after the read; garbage otherwise.
  logic       pv = 1'b0;
  logic [3:0] pxa = '0, pya = '0;
  always @(negedge clk) begin
    pv = read_SRAM_raw; pxa = x_addr_raw; pya = y_addr_raw;
  end
  always @(posedge clk)
    SRAM_in_raw <= (pv && pxa < 5 && pya < 5) ? mem[pya][pxa] : 8'($urandom);

  always @(negedge clk) begin
    int e_rd, e_xr, e_yr, e_wr, e_xg, e_yg, e_wd, e_dn, ph, p, t;
    e_rd = 0; e_xr = 0; e_yr = 0; e_wr = 0; e_xg = 0; e_yg = 0; e_wd = 0; e_dn = 0;
    if (mstate == 1) begin
      ph = mcyc % 11;
      if (ph >= 1 && ph <= 9) begin
        p = (mcyc - 1) / 11; t = ph - 1; e_rd = 1;
        e_xr = clampm(p % (mmx + 1) + t % 3 - 1, mmx);
        e_yr = clampm(p / (mmx + 1) + t / 3 - 1, mmy);
      end else if (ph == 0) begin
        p = mcyc / 11 - 1; e_wr = 1;
        e_xg = p % (mmx + 1); e_yg = p / (mmx + 1); e_wd = blur(e_xg, e_yg);
      end
    end else if (mstate == 2) e_dn = 1;
    chk("read_SRAM_raw", int'(read_SRAM_raw), e_rd);
    chk("x_addr_raw", int'(x_addr_raw), e_xr);
    chk("y_addr_raw", int'(y_addr_raw), e_yr);
    chk("write_SRAM_gaus", int'(write_SRAM_gaus), e_wr);
    chk("gaus_sample_flag", int'(gaus_sample_flag), e_wr);
    chk("x_addr_gaus", int'(x_addr_gaus), e_xg);
    chk("y_addr_gaus", int'(y_addr_gaus), e_yg);
    chk("SRAM_gaus_wdata", int'(SRAM_gaus_wdata), e_wd);
    chk("gaus_done", int'(gaus_done), e_dn);
    if (write_SRAM_gaus && x_addr_gaus < 5 && y_addr_gaus < 5) begin
      gimg[y_addr_gaus][x_addr_gaus] = SRAM_gaus_wdata;
      wcount++;
      if (first_w == 0) first_w = mcyc;
      last_w = mcyc;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill(input int mode, input int val);
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        case (mode)
          0: mem[y][x] = 8'(val);
          1: mem[y][x] = (x == 2 && y == 2) ? 8'(val) : 8'd0;
          2: mem[y][x] = (x == 0 && y == 0) ? 8'(val) : 8'd0;
          default: mem[y][x] = 8'($urandom);
        endcase
        gimg[y][x] = 8'hxx;
      end
  endtask

  // Start a frame; inputs are scrambled after the start to show latched copies are used.
  task automatic run_frame(input int pulse_at);
    int c;
    tick(); new_trans = 1'b1;
    tick(); new_trans = 1'b0;
    max_x = 3'($urandom_range(0, 4)); max_y = 3'($urandom_range(0, 4));
    c = 0;
    while (mstate != 2 && c < 400) begin
      new_trans = (pulse_at > 0 && mcyc == pulse_at) ? 1'b1 : 1'b0;
      tick(); c++;
    end
    new_trans = 1'b0;
    chk("frame_completes", int'(mstate == 2), 1);
    chk("write_count", wcount, mn);
    tick();
  endtask

  initial begin
    int c;
    for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) mem[y][x] = '0;
    repeat (3) tick();
    chk("reset_rd", int'(read_SRAM_raw), 0);
    chk("reset_done", int'(gaus_done), 0);
    n_rst = 1'b1;
    repeat (2) tick();

    // Flat 3x3 frame: every output 100, 99 cycles.
    fill(0, 100); max_x = 3'd2; max_y = 3'd2;
    run_frame(0);
    chk("flat_first_write_cycle", first_w, 11);
    chk("flat_last_write_cycle", last_w, 99);
    chk("flat_pixel_1_1", int'(gimg[1][1]), 100);
    chk("flat_pixel_2_2", int'(gimg[2][2]), 100);

    // Impulse at centre of 5x5, with new_trans pulsed during pixel 3.
    fill(1, 255); max_x = 3'd4; max_y = 3'd4;
    run_frame(25);
    chk("impulse_model_center", blur(2, 2), 64);
    chk("impulse_center", int'(gimg[2][2]), 64);
    chk("impulse_edge", int'(gimg[2][1]), 32);
    chk("impulse_edge2", int'(gimg[3][2]), 32);
    chk("impulse_diag", int'(gimg[1][1]), 16);
    chk("impulse_far", int'(gimg[0][0]), 0);

    // Corner replication; the new_trans here also restarts from DONE.
    fill(2, 160); max_x = 3'd4; max_y = 3'd4;
    run_frame(0);
    chk("corner_model", blur(0, 0), 90);
    chk("corner_pixel", int'(gimg[0][0]), 90);
    chk("corner_neighbor", int'(gimg[0][1]), 30);

    // Reset during READ of pixel 4, then idle, then a full frame.
    fill(3, 0); max_x = 3'd4; max_y = 3'd4;
    tick(); new_trans = 1'b1;
    tick(); new_trans = 1'b0;
    c = 0;
    while (!(mstate == 1 && mcyc == 36) && c < 100) begin tick(); c++; end
    chk("reached_pixel4", mcyc, 36);
    n_rst = 1'b0;
    #1;
    chk("rst_read_zero", int'(read_SRAM_raw), 0);
    chk("rst_xaddr_zero", int'(x_addr_raw), 0);
    chk("rst_write_zero", int'(write_SRAM_gaus), 0);
    chk("rst_done_zero", int'(gaus_done), 0);
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (4) tick();
    run_frame(0);

    // Randomized frames including single-row/column sizes.
    for (int r = 0; r < 8; r++) begin
      fill(3, 0);
      max_x = 3'($urandom_range(0, 4)); max_y = 3'($urandom_range(0, 4));
      if (r == 0) max_x = 3'd0;
      if (r == 1) max_y = 3'd0;
      run_frame((r % 2 == 1) ? int'($urandom_range(2, 30)) : 0);
      repeat (int'($urandom_range(0, 3))) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
